clock_divider_prog: RTL and testbench

Parametrised, run-time reprogrammable successor to the fixed-ratio scaled-clock divider. It divides `CLOCK_50` by a programmable half-period count, producing a 50 % duty toggling `scaledClock` and a one-cycle `tick` strobe at every toggle. New divisors are accepted at any time through a valid-strobe interface but are applied only on a half-period boundary, so no shortened or stretched half-periods appear. It feeds display-multiplex, keypad-scan and blink timing in the calculator.

---
 rtl/clock_divider_prog_if.sv | 41 ++++
 rtl/clock_divider_prog.sv | 97 +++++++++
 tb/tb_clock_divider_prog.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_prog_if
// Description : Control/status bundle of the programmable clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_divider_prog_if #(
    parameter int CNT_W = 27
);
    logic             enable;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             scaledClock;
    logic             tick;
    logic [CNT_W-1:0] active_div;
    logic             cfg_busy;
    logic             cfg_err;

    modport master (
        output enable,
        output cfg_valid,
        output cfg_div,
        input  scaledClock,
        input  tick,
        input  active_div,
        input  cfg_busy,
        input  cfg_err
    );

    modport slave (
        input  enable,
        input  cfg_valid,
        input  cfg_div,
        output scaledClock,
        output tick,
        output active_div,
        output cfg_busy,
        output cfg_err
    );
endinterface : clock_divider_prog_if
`default_nettype wire

// File: rtl/clock_divider_prog.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_prog
// Description : Run-time reprogrammable 50 % duty divider with tick strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_prog #(
    parameter int CNT_W       = 27,
    parameter int DIV_DEFAULT = 50000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    clock_divider_prog_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_DIV_DEFAULT = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

    logic [CNT_W-1:0] count_q,       count_d;
    logic [CNT_W-1:0] active_div_q,  active_div_d;
    logic [CNT_W-1:0] pending_div_q, pending_div_d;
    logic             pending_q,     pending_d;
    logic             scaled_q,      scaled_d;
    logic             tick_q,        tick_d;
    logic             cfg_err_q,     cfg_err_d;

    logic             w_cfg_write;
    logic             w_cfg_illegal;
    logic             w_boundary;
    logic             w_apply;

    assign w_cfg_write   = bus.cfg_valid && (bus.cfg_div != '0);
    assign w_cfg_illegal = bus.cfg_valid && (bus.cfg_div == '0);
    // Exact equality: count clears at H-1, so each half-period is H cycles.
    assign w_boundary    = bus.enable && (count_q == (active_div_q - c_ONE));
    // A pending divisor only takes effect where no half-period is in flight.
    assign w_apply       = pending_q && (w_boundary || !bus.enable);

    always_comb begin
        count_d       = count_q;
        active_div_d  = active_div_q;
        pending_div_d = pending_div_q;
        pending_d     = pending_q;
        scaled_d      = scaled_q;
        tick_d        = 1'b0;
        cfg_err_d     = w_cfg_illegal;

        if (!bus.enable) begin
            count_d = '0;
        end else if (w_boundary) begin
            count_d  = '0;
            scaled_d = ~scaled_q;
            tick_d   = 1'b1;
        end else begin
            count_d = count_q + c_ONE;
        end

        if (w_apply) begin
            active_div_d = pending_div_q;
            pending_d    = 1'b0;
        end

        // A write landing on the boundary re-arms pending for the next one.
        if (w_cfg_write) begin
            pending_div_d = bus.cfg_div;
            pending_d     = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_q       <= '0;
            active_div_q  <= c_DIV_DEFAULT;
            pending_div_q <= c_DIV_DEFAULT;
            pending_q     <= 1'b0;
            scaled_q      <= 1'b0;
            tick_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            count_q       <= count_d;
            active_div_q  <= active_div_d;
            pending_div_q <= pending_div_d;
            pending_q     <= pending_d;
            scaled_q      <= scaled_d;
            tick_q        <= tick_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign bus.scaledClock = scaled_q;
    assign bus.tick        = tick_q;
    assign bus.active_div  = active_div_q;
    assign bus.cfg_busy    = pending_q;
    assign bus.cfg_err     = cfg_err_q;

endmodule : clock_divider_prog
`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_divider_prog
// Description : Table-driven self-checking bench for clock_divider_prog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_divider_prog;

    localparam int CNT_W       = 8;
    localparam int DIV_DEFAULT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_divider_prog_if #(.CNT_W(CNT_W)) dut_if ();

    clock_divider_prog #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (dut_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             en;
        logic             vld;
        logic [CNT_W-1:0] div;
        logic             sc;
        logic             tick;
        logic [CNT_W-1:0] act;
        logic             busy;
        logic             err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Inputs applied on an edge, followed by outputs expected just after it.
    function automatic void add(input int r, input int en, input int vld, input int div,
                                input int sc, input int tk, input int act,
                                input int bsy, input int er);
        vec_t v;
        v.rst  = (r   != 0);
        v.en   = (en  != 0);
        v.vld  = (vld != 0);
        v.div  = CNT_W'(div);
        v.sc   = (sc  != 0);
        v.tick = (tk  != 0);
        v.act  = CNT_W'(act);
        v.busy = (bsy != 0);
        v.err  = (er  != 0);
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic en, input logic vld, input logic [CNT_W-1:0] div);
        rst              = r;
        dut_if.enable    = en;
        dut_if.cfg_valid = vld;
        dut_if.cfg_div   = div;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    logic [CNT_W+3:0] got, exp;
    logic             sc_before;
    int               gap;
    bit               seen;

    initial begin : stim
        drive(1'b1, 1'b0, 1'b0, '0);

        // Default H=4, stray cfg during reset ignored
        add(1,0,1,7, 0,0,4,0,0);
        add(0,1,0,0, 0,0,4,0,0); add(0,1,0,0, 0,0,4,0,0); add(0,1,0,0, 0,0,4,0,0);
        add(0,1,0,0, 1,1,4,0,0);
        add(0,1,0,0, 1,0,4,0,0); add(0,1,0,0, 1,0,4,0,0); add(0,1,0,0, 1,0,4,0,0);
        add(0,1,0,0, 0,1,4,0,0);
        add(0,1,0,0, 0,0,4,0,0); add(0,1,0,0, 0,0,4,0,0); add(0,1,0,0, 0,0,4,0,0);
        add(0,1,0,0, 1,1,4,0,0);

        // Write 2 on edge 2: busy edges 2-3, ticks at 4, 6, 8
        add(1,0,0,0, 0,0,4,0,0);
        add(0,1,0,0, 0,0,4,0,0);
        add(0,1,1,2, 0,0,4,1,0);
        add(0,1,0,0, 0,0,4,1,0);
        add(0,1,0,0, 1,1,2,0,0);
        add(0,1,0,0, 1,0,2,0,0);
        add(0,1,0,0, 0,1,2,0,0);
        add(0,1,0,0, 0,0,2,0,0);
        add(0,1,0,0, 1,1,2,0,0);

        // Last write wins: 3 then 6, H=6 from the edge-4 boundary
        add(1,0,0,0, 0,0,4,0,0);
        add(0,1,1,3, 0,0,4,1,0);
        add(0,1,1,6, 0,0,4,1,0);
        add(0,1,0,0, 0,0,4,1,0);
        add(0,1,0,0, 1,1,6,0,0);
        add(0,1,0,0, 1,0,6,0,0); add(0,1,0,0, 1,0,6,0,0); add(0,1,0,0, 1,0,6,0,0);
        add(0,1,0,0, 1,0,6,0,0); add(0,1,0,0, 1,0,6,0,0);
        add(0,1,0,0, 0,1,6,0,0);

        // Illegal zero: one-cycle error, pending state untouched
        add(1,0,0,0, 0,0,4,0,0);
        add(0,1,0,0, 0,0,4,0,0);
        add(0,1,1,0, 0,0,4,0,1);
        add(0,1,0,0, 0,0,4,0,0);
        add(0,1,0,0, 1,1,4,0,0);
        add(0,1,1,3, 1,0,4,1,0);
        add(0,1,1,0, 1,0,4,1,1);
        add(0,1,0,0, 1,0,4,1,0);
        add(0,1,0,0, 0,1,3,0,0);
        add(0,1,0,0, 0,0,3,0,0); add(0,1,0,0, 0,0,3,0,0);
        add(0,1,0,0, 1,1,3,0,0);

        // Enable low for 3 edges, then a write applied while disabled
        add(1,0,0,0, 0,0,4,0,0);
        add(0,1,0,0, 0,0,4,0,0); add(0,1,0,0, 0,0,4,0,0); add(0,1,0,0, 0,0,4,0,0);
        add(0,1,0,0, 1,1,4,0,0);
        add(0,1,0,0, 1,0,4,0,0);
        add(0,0,0,0, 1,0,4,0,0); add(0,0,0,0, 1,0,4,0,0); add(0,0,0,0, 1,0,4,0,0);
        add(0,1,0,0, 1,0,4,0,0); add(0,1,0,0, 1,0,4,0,0); add(0,1,0,0, 1,0,4,0,0);
        add(0,1,0,0, 0,1,4,0,0);
        add(0,0,1,5, 0,0,4,1,0);
        add(0,0,0,0, 0,0,5,0,0);
        add(0,1,0,0, 0,0,5,0,0); add(0,1,0,0, 0,0,5,0,0);
        add(0,1,0,0, 0,0,5,0,0); add(0,1,0,0, 0,0,5,0,0);
        add(0,1,0,0, 1,1,5,0,0);

        // H=1 continuous tick, then mid-run reset discards a pending write
        add(1,0,0,0, 0,0,4,0,0);
        add(0,1,1,1, 0,0,4,1,0);
        add(0,1,0,0, 0,0,4,1,0);
        add(0,1,0,0, 0,0,4,1,0);
        add(0,1,0,0, 1,1,1,0,0);
        add(0,1,0,0, 0,1,1,0,0);
        add(0,1,0,0, 1,1,1,0,0);
        add(0,1,1,9, 0,1,1,1,0);
        add(1,1,0,0, 0,0,4,0,0);
        add(0,1,0,0, 0,0,4,0,0); add(0,1,0,0, 0,0,4,0,0); add(0,1,0,0, 0,0,4,0,0);
        add(0,1,0,0, 1,1,4,0,0);

        // Write in the boundary cycle is deferred to the following boundary
        add(1,0,0,0, 0,0,4,0,0);
        add(0,1,0,0, 0,0,4,0,0); add(0,1,0,0, 0,0,4,0,0); add(0,1,0,0, 0,0,4,0,0);
        add(0,1,1,2, 1,1,4,1,0);
        add(0,1,0,0, 1,0,4,1,0); add(0,1,0,0, 1,0,4,1,0); add(0,1,0,0, 1,0,4,1,0);
        add(0,1,0,0, 0,1,2,0,0);
        add(0,1,0,0, 0,0,2,0,0);
        add(0,1,0,0, 1,1,2,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].div);
            @(posedge clk);
            #1;
            got = {dut_if.scaledClock, dut_if.tick, dut_if.active_div, dut_if.cfg_busy, dut_if.cfg_err};
            exp = {vecs[i].sc, vecs[i].tick, vecs[i].act, vecs[i].busy, vecs[i].err};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL vec[%0d]: got sc=%b tick=%b act=%0d busy=%b err=%b, want sc=%b tick=%b act=%0d busy=%b err=%b",
                         i, dut_if.scaledClock, dut_if.tick, dut_if.active_div, dut_if.cfg_busy, dut_if.cfg_err,
                         vecs[i].sc, vecs[i].tick, vecs[i].act, vecs[i].busy, vecs[i].err);
            end
        end

        // Maximum half-period: tick spacing must be exactly 2^CNT_W-1
        drive(1'b1, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, CNT_W'(255));
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, '0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (dut_if.tick) seen = 1'b1;
        end
        checks++;
        if (!seen || dut_if.active_div !== CNT_W'(255)) begin
            errors++;
            $display("FAIL max_apply: tick_seen=%0b act=%0d, want tick_seen=1 act=255", seen, dut_if.active_div);
        end

        sc_before = dut_if.scaledClock;
        gap       = 0;
        seen      = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            @(posedge clk); #1;
            gap++;
            if (dut_if.tick) seen = 1'b1;
        end
        checks++;
        if (!seen || gap != 255 || dut_if.scaledClock === sc_before) begin
            errors++;
            $display("FAIL max_gap: tick_seen=%0b gap=%0d toggled=%0b, want tick_seen=1 gap=255 toggled=1",
                     seen, gap, dut_if.scaledClock !== sc_before);
        end

        drive(1'b0, 1'b0, 1'b0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_clock_divider_prog
`default_nettype wire
